// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC datapath and its sample stream loader.
package hdc_pkg;

    localparam int unsigned FEATURE_COUNT = 4;
    localparam int unsigned FEAT_W        = 16;
    localparam int unsigned CLASS_W       = 5;
    localparam int unsigned NUM_CLASSES   = 26;
    localparam int unsigned SAMPLE_CNT_W  = 11;
    localparam int unsigned WORD_IDX_W    = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RESYNC,
        LAUNCH,
        WAIT,
        FIN_TRAIN,
        FIN_TEST,
        DONE
    } loader_state_t;

    typedef enum logic {
        PHASE_TRAIN,
        PHASE_TEST
    } phase_t;

    // A label names one of the trained classes only below NUM_CLASSES.
    function automatic logic label_is_valid(input logic [CLASS_W-1:0] label);
        return label < CLASS_W'(NUM_CLASSES);
    endfunction

endpackage

// File: rtl/feature_frame_assembler.sv
// Collects accepted stream beats into the parallel feature array and
// classifies each frame end as good, bad-label, short or long.
module feature_frame_assembler
    import hdc_pkg::*;
(
    input  logic                                    clk_i,
    input  logic                                    nrst_i,
    input  logic                                    beat_i,
    input  logic [FEAT_W-1:0]                       data_i,
    input  logic                                    last_i,
    input  logic [CLASS_W-1:0]                      label_i,
    output logic [FEATURE_COUNT-1:0][FEAT_W-1:0]    values_o,
    output logic [CLASS_W-1:0]                      class_o,
    output logic                                    frame_ok_o,
    output logic                                    label_bad_o,
    output logic                                    frame_short_o,
    output logic                                    frame_long_o
);

    logic [WORD_IDX_W-1:0]                   word_idx_q;
    logic [FEATURE_COUNT-1:0][FEAT_W-1:0]    values_q;
    logic [CLASS_W-1:0]                      class_q;
    logic                                    at_end;
    logic                                    label_ok;

    assign at_end   = (word_idx_q == WORD_IDX_W'(FEATURE_COUNT - 1));
    assign label_ok = label_is_valid(label_i);

    // Frame-end classification of the beat being accepted this cycle.
    always_comb begin
        frame_ok_o    = beat_i && last_i && at_end && label_ok;
        label_bad_o   = beat_i && last_i && at_end && !label_ok;
        frame_short_o = beat_i && last_i && !at_end;
        frame_long_o  = beat_i && !last_i && at_end;
    end

    // Store each accepted word at its index; any frame end (good or bad) rewinds the index.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            word_idx_q <= '0;
            values_q   <= '0;
            class_q    <= '0;
        end else if (beat_i) begin
            values_q[word_idx_q] <= data_i;
            if (last_i || at_end) begin
                word_idx_q <= '0;
            end else begin
                word_idx_q <= word_idx_q + 1'b1;
            end
            if (frame_ok_o) begin
                class_q <= label_i;
            end
        end
    end

    assign values_o = values_q;
    assign class_o  = class_q;

endmodule

// File: rtl/sample_stream_loader.sv
// Upstream feeder for the one-shot HDC datapath: assembles streamed samples,
// launches them one at a time and sequences the training then testing phases.
module sample_stream_loader
    import hdc_pkg::*;
#(
    parameter int unsigned TRAIN_SAMPLES = 1024,
    parameter int unsigned TEST_SAMPLES  = 1024
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic                                    en,
    input  logic                                    start,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [FEAT_W-1:0]                       s_data,
    input  logic [CLASS_W-1:0]                      s_label,
    input  logic                                    s_last,
    input  logic                                    sample_done,
    output logic [FEATURE_COUNT-1:0][FEAT_W-1:0]    input_values,
    output logic [CLASS_W-1:0]                      class_select_bits,
    output logic                                    start_mapping,
    output logic                                    training_dataset_finished,
    output logic                                    testing_dataset_finished,
    output logic                                    busy,
    output logic                                    frame_error,
    output logic                                    label_error
);

    localparam logic [SAMPLE_CNT_W-1:0] TRAIN_CNT = SAMPLE_CNT_W'(TRAIN_SAMPLES);
    localparam logic [SAMPLE_CNT_W-1:0] TEST_CNT  = SAMPLE_CNT_W'(TEST_SAMPLES);

    loader_state_t             state_q;
    phase_t                    phase_q;
    logic [SAMPLE_CNT_W-1:0]   sample_cnt_q;
    logic [SAMPLE_CNT_W-1:0]   sample_cnt_d;
    logic                      frame_error_q;
    logic                      label_error_q;

    logic                      beat;
    logic                      frame_ok;
    logic                      label_bad;
    logic                      frame_short;
    logic                      frame_long;

    // Only FILL beats reach the assembler; RESYNC beats are discarded.
    assign beat         = s_valid && s_ready && (state_q == FILL);
    assign sample_cnt_d = sample_cnt_q + 1'b1;

    feature_frame_assembler u_assembler (
        .clk_i         (clk),
        .nrst_i        (nrst),
        .beat_i        (beat),
        .data_i        (s_data),
        .last_i        (s_last),
        .label_i       (s_label),
        .values_o      (input_values),
        .class_o       (class_select_bits),
        .frame_ok_o    (frame_ok),
        .label_bad_o   (label_bad),
        .frame_short_o (frame_short),
        .frame_long_o  (frame_long)
    );

    // Sequencing FSM: phase, sample count and sticky error flags; frozen while en is low.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= IDLE;
            phase_q       <= PHASE_TRAIN;
            sample_cnt_q  <= '0;
            frame_error_q <= 1'b0;
            label_error_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= FILL;
                        phase_q       <= PHASE_TRAIN;
                        sample_cnt_q  <= '0;
                        frame_error_q <= 1'b0;
                        label_error_q <= 1'b0;
                    end
                end
                FILL: begin
                    if (frame_ok) begin
                        state_q <= LAUNCH;
                    end else if (label_bad) begin
                        label_error_q <= 1'b1;
                    end else if (frame_short) begin
                        frame_error_q <= 1'b1;
                    end else if (frame_long) begin
                        frame_error_q <= 1'b1;
                        state_q       <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (s_valid && s_last) begin
                        state_q <= FILL;
                    end
                end
                LAUNCH: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (sample_done) begin
                        sample_cnt_q <= sample_cnt_d;
                        if (phase_q == PHASE_TRAIN && sample_cnt_d == TRAIN_CNT) begin
                            state_q <= FIN_TRAIN;
                        end else if (phase_q == PHASE_TEST && sample_cnt_d == TEST_CNT) begin
                            state_q <= FIN_TEST;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FIN_TRAIN: begin
                    phase_q      <= PHASE_TEST;
                    sample_cnt_q <= '0;
                    state_q      <= FILL;
                end
                FIN_TEST: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and pulses decode the registered state; en low suppresses them
    // so a pending pulse state simply waits for the next enabled cycle.
    always_comb begin
        s_ready                   = en && (state_q == FILL || state_q == RESYNC);
        start_mapping             = en && (state_q == LAUNCH);
        training_dataset_finished = en && (state_q == FIN_TRAIN);
        testing_dataset_finished  = en && (state_q == FIN_TEST);
        busy                      = (state_q != IDLE) && (state_q != DONE);
    end

    assign frame_error = frame_error_q;
    assign label_error = label_error_q;

endmodule

// File: tb/tb_sample_stream_loader.sv
// Randomized self-checking bench for sample_stream_loader with a frame-level reference model.
module tb_sample_stream_loader;
    import hdc_pkg::*;

    localparam int unsigned N_TRAIN = 2;
    localparam int unsigned N_TEST  = 3;
    localparam int          BUDGET  = 500;

    typedef struct {
        logic [FEATURE_COUNT-1:0][FEAT_W-1:0] vals;
        logic [CLASS_W-1:0]                   lab;
    } exp_t;

    logic                                  clk = 1'b0;
    logic                                  nrst = 1'b0;
    logic                                  en = 1'b1;
    logic                                  start = 1'b0;
    logic                                  s_valid = 1'b0;
    logic                                  s_ready;
    logic [FEAT_W-1:0]                     s_data = '0;
    logic [CLASS_W-1:0]                    s_label = '0;
    logic                                  s_last = 1'b0;
    logic                                  sample_done = 1'b0;
    logic [FEATURE_COUNT-1:0][FEAT_W-1:0]  input_values;
    logic [CLASS_W-1:0]                    class_select_bits;
    logic                                  start_mapping;
    logic                                  training_dataset_finished;
    logic                                  testing_dataset_finished;
    logic                                  busy;
    logic                                  frame_error;
    logic                                  label_error;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   ev[$];          // 0 = launch, 1 = training finished, 2 = testing finished
    bit   auto_done = 1'b1;
    int   done_delay = 5;

    sample_stream_loader #(
        .TRAIN_SAMPLES (N_TRAIN),
        .TEST_SAMPLES  (N_TEST)
    ) dut (
        .clk                       (clk),
        .nrst                      (nrst),
        .en                        (en),
        .start                     (start),
        .s_valid                   (s_valid),
        .s_ready                   (s_ready),
        .s_data                    (s_data),
        .s_label                   (s_label),
        .s_last                    (s_last),
        .sample_done               (sample_done),
        .input_values              (input_values),
        .class_select_bits         (class_select_bits),
        .start_mapping             (start_mapping),
        .training_dataset_finished (training_dataset_finished),
        .testing_dataset_finished  (testing_dataset_finished),
        .busy                      (busy),
        .frame_error               (frame_error),
        .label_error               (label_error)
    );

    always #5 clk = ~clk;

    // Event log of every output pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_mapping === 1'b1) ev.push_back(0);
        if (training_dataset_finished === 1'b1) ev.push_back(1);
        if (testing_dataset_finished === 1'b1) ev.push_back(2);
    end

    // Launch checker and datapath stand-in: checks each launched sample against
    // the model, then holds it for done_delay cycles before returning sample_done.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (start_mapping === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_launch: got start_mapping=1 required no launch");
                end else begin
                    cur = exp_q.pop_front();
                    if (input_values !== cur.vals || class_select_bits !== cur.lab) begin
                        miscompares++;
                        $display("FAIL launch_data: got vals=%h class=%0d required vals=%h class=%0d",
                                 input_values, class_select_bits, cur.vals, cur.lab);
                    end
                    if (auto_done) begin
                        repeat (done_delay) begin
                            @(negedge clk);
                            vectors++;
                            if (s_ready !== 1'b0 || input_values !== cur.vals || start_mapping !== 1'b0) begin
                                miscompares++;
                                $display("FAIL wait_hold: got s_ready=%b vals=%h sm=%b required 0/%h/0",
                                         s_ready, input_values, start_mapping, cur.vals);
                            end
                        end
                        sample_done = 1'b1;
                        @(negedge clk);
                        sample_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog");
    end

    task automatic put_word(input logic [FEAT_W-1:0] d, input logic last, input logic [CLASS_W-1:0] lab);
        int b = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_label = lab;
        while (s_ready !== 1'b1 && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        if (b >= BUDGET) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got s_ready=%b required 1 within %0d cycles", s_ready, BUDGET);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Frame-level model: exactly FEATURE_COUNT words with a label below NUM_CLASSES
    // launches; other lengths raise frame_error, bad labels raise label_error.
    task automatic send_frame(input int n, input logic [CLASS_W-1:0] lab, input bit gaps, input bit fixed);
        logic [FEAT_W-1:0] w[8];
        exp_t e;
        bit good;
        for (int i = 0; i < n; i++) w[i] = fixed ? FEAT_W'(i + 1) : FEAT_W'($urandom);
        good = (n == int'(FEATURE_COUNT)) && (int'(lab) < int'(NUM_CLASSES));
        if (good) begin
            for (int i = 0; i < n; i++) e.vals[i] = w[i];
            e.lab = lab;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            put_word(w[i], i == n - 1, lab);
        end
        vectors++;
        if (good) begin
            if (start_mapping !== 1'b1) begin
                miscompares++;
                $display("FAIL launch_latency: got start_mapping=%b required 1 one cycle after last beat", start_mapping);
            end
        end else if (n != int'(FEATURE_COUNT)) begin
            if (frame_error !== 1'b1 || start_mapping !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_frame_len%0d: got frame_error=%b sm=%b required 1/0", n, frame_error, start_mapping);
            end
        end else begin
            if (label_error !== 1'b1 || start_mapping !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_label: got label_error=%b sm=%b required 1/0", label_error, start_mapping);
            end
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || frame_error !== 1'b0 || label_error !== 1'b0) begin
            miscompares++;
            $display("FAIL start_run: got busy=%b s_ready=%b ferr=%b lerr=%b required 1/1/0/0",
                     busy, s_ready, frame_error, label_error);
        end
    endtask

    task automatic finish_run();
        int b = 0;
        while (busy !== 1'b0 && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL run_done: got busy=%b s_ready=%b required 0/0", busy, s_ready);
        end
        vectors++;
        if (ev.size() != int'(N_TRAIN + N_TEST + 2)) begin
            miscompares++;
            $display("FAIL event_count: got %0d events required %0d", ev.size(), N_TRAIN + N_TEST + 2);
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                int want;
                want = (i < int'(N_TRAIN)) ? 0 : (i == int'(N_TRAIN)) ? 1 : (i == ev.size() - 1) ? 2 : 0;
                if (ev[i] != want) begin
                    miscompares++;
                    $display("FAIL event_order[%0d]: got %0d required %0d", i, ev[i], want);
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (input_values !== '0 || class_select_bits !== '0 || s_ready !== 1'b0 || busy !== 1'b0 ||
            start_mapping !== 1'b0 || training_dataset_finished !== 1'b0 ||
            testing_dataset_finished !== 1'b0 || frame_error !== 1'b0 || label_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got vals=%h cls=%0d rdy=%b busy=%b sm=%b ferr=%b lerr=%b required all 0",
                     input_values, class_select_bits, s_ready, busy, start_mapping, frame_error, label_error);
        end
        nrst = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_state: got s_ready=%b busy=%b required 0/0", s_ready, busy);
        end
    endtask

    task automatic test_phase_sequencing();
        ev.delete();
        done_delay = 5;
        start_run();
        send_frame(FEATURE_COUNT, 5'd7, 1'b0, 1'b1);
        vectors++;
        for (int i = 0; i < int'(FEATURE_COUNT); i++) begin
            if (input_values[i] !== FEAT_W'(i + 1)) begin
                miscompares++;
                $display("FAIL first_sample[%0d]: got %0d required %0d", i, input_values[i], i + 1);
            end
        end
        vectors++;
        if (class_select_bits !== 5'd7) begin
            miscompares++;
            $display("FAIL first_class: got %0d required 7", class_select_bits);
        end
        for (int i = 1; i < int'(N_TRAIN + N_TEST); i++)
            send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_back_to_back();
        ev.delete();
        done_delay = 50;
        start_run();
        for (int i = 0; i < int'(N_TRAIN + N_TEST); i++)
            send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b1, 1'b0);
        finish_run();
        done_delay = 5;
    endtask

    task automatic test_bad_frames();
        ev.delete();
        start_run();
        send_frame(3, 5'd3, 1'b1, 1'b0);
        send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b1, 1'b0);
        send_frame(6, 5'd4, 1'b1, 1'b0);
        send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b1, 1'b0);
        send_frame(FEATURE_COUNT, 5'd26, 1'b1, 1'b0);
        send_frame(FEATURE_COUNT, 5'd25, 1'b1, 1'b0);
        vectors++;
        if (class_select_bits !== 5'd25) begin
            miscompares++;
            $display("FAIL label_max: got %0d required 25", class_select_bits);
        end
        for (int i = 3; i < int'(N_TRAIN + N_TEST); i++)
            send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_en_reset();
        ev.delete();
        auto_done = 1'b0;
        start_run();
        send_frame(FEATURE_COUNT, CLASS_W'($urandom_range(0, NUM_CLASSES - 1)), 1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        sample_done = 1'b1;
        @(negedge clk);
        sample_done = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || start_mapping !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low_hold: got s_ready=%b busy=%b sm=%b required 0/1/0", s_ready, busy, start_mapping);
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ignored: got s_ready=%b required 0", s_ready);
        end
        sample_done = 1'b1;
        @(negedge clk);
        sample_done = 1'b0;
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL done_latency: got s_ready=%b required 1", s_ready);
        end
        en = 1'b0;
        #1;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low_ready: got s_ready=%b required 0", s_ready);
        end
        @(negedge clk);
        en = 1'b1;
        put_word(FEAT_W'($urandom), 1'b0, 5'd1);
        put_word(FEAT_W'($urandom), 1'b0, 5'd1);
        nrst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || input_values !== '0 || class_select_bits !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b rdy=%b vals=%h cls=%0d required 0/0/0/0",
                     busy, s_ready, input_values, class_select_bits);
        end
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (ev.size() != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_finish_after_reset: got %0d events busy=%b required 1 event busy=0", ev.size(), busy);
        end
        auto_done = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_phase_sequencing();
        test_back_to_back();
        test_bad_frames();
        test_en_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_launches: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sample_stream_loader.md
Name: sample_stream_loader

Overview:
- Upstream feeder for the one-shot HDC datapath.
- Accepts a serial valid/ready stream of 16-bit feature words, one sample of FEATURE_COUNT words plus a 5-bit class label at a time, and assembles it into the parallel input_values array.
- Drives the HDC top's control inputs: start_mapping, class_select_bits, training_dataset_finished and testing_dataset_finished.
- Sequences the training phase first, then the testing phase, pacing samples on a per-sample completion input.

Parameters:
- FEATURE_COUNT, from shared package: features per sample.
- FEAT_W, 16: feature word width.
- CLASS_W, 5: label width.
- NUM_CLASSES, 26: number of valid labels, 0..25.
- TRAIN_SAMPLES, 1024: samples in the training phase, range 1..2047.
- TEST_SAMPLES, 1024: samples in the testing phase, range 1..2047.

Ports:
- clk  in  1  clock
- nrst  in  1  reset; one clock; reset is synchronous and active-low
- en  in  1  global enable; when low, all state and outputs hold and s_ready=0
- start  in  1  1-cycle pulse; begins a run from IDLE
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&s_ready
- s_data  in  FEAT_W  feature word
- s_label  in  CLASS_W  class label; sampled on the s_last beat
- s_last  in  1  marks the final word of a sample
- sample_done  in  1  1-cycle pulse from the datapath: current sample fully consumed
- input_values  out  FEAT_W x FEATURE_COUNT  assembled sample
- class_select_bits  out  CLASS_W  label of the launched sample
- start_mapping  out  1  1-cycle pulse launching a sample
- training_dataset_finished  out  1  1-cycle pulse
- testing_dataset_finished  out  1  1-cycle pulse
- busy  out  1  high whenever state is not IDLE or DONE
- frame_error  out  1  sticky; cleared by start or reset
- label_error  out  1  sticky; cleared by start or reset

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state=IDLE; all outputs 0; input_values all 0; counters 0.
  - Reset mid-operation abandons the run; no finished pulse is emitted.
- States:
  - IDLE: s_ready=0. start -> FILL, phase=TRAIN, sample_cnt=0, word_idx=0, errors cleared.
  - FILL: s_ready=1.
    - Each accepted beat writes s_data to input_values[word_idx] and increments word_idx.
    - Accepted beat with s_last=1 and word_idx==FEATURE_COUNT-1:
      - Label < NUM_CLASSES -> latch class_select_bits, go to LAUNCH.
      - Label >= NUM_CLASSES -> set label_error, drop the sample, word_idx=0, stay in FILL; sample_cnt unchanged.
    - Accepted beat with s_last=1 and word_idx < FEATURE_COUNT-1 (short frame) -> set frame_error, drop the sample, word_idx=0, stay in FILL.
    - Accepted beat with s_last=0 and word_idx==FEATURE_COUNT-1 (long frame) -> set frame_error, go to RESYNC.
  - RESYNC: s_ready=1; words are discarded until an accepted beat with s_last=1, then FILL with word_idx=0.
  - LAUNCH: s_ready=0; start_mapping=1 for exactly one cycle; next state WAIT.
  - WAIT: s_ready=0; input_values and class_select_bits are held stable. On sample_done:
    - sample_cnt+1.
    - Phase TRAIN and new count == TRAIN_SAMPLES -> FIN_TRAIN.
    - Phase TEST and new count == TEST_SAMPLES -> FIN_TEST.
    - Otherwise -> FILL.
  - FIN_TRAIN: training_dataset_finished=1 for one cycle; phase=TEST; sample_cnt=0; next state FILL.
  - FIN_TEST: testing_dataset_finished=1 for one cycle; next state DONE.
  - DONE: s_ready=0; busy=0. start -> restarts exactly as from IDLE.
- Latency:
  - Last accepted beat -> start_mapping is 1 cycle (FILL -> LAUNCH -> pulse is registered).
  - sample_done -> s_ready=1 is 1 cycle.
- Edge cases:
  - sample_done outside WAIT is ignored.
  - start outside IDLE/DONE is ignored.
  - When en=0, handshakes and pulses are suppressed. A pending pulse state holds and fires on the first cycle en=1.
- Widths: sample_cnt is 11 bits; word_idx is $clog2(FEATURE_COUNT) bits. Neither wraps in legal operation.
- Outputs are registered. start_mapping, the finished pulses and s_ready are decoded from registered state.

Decomposition:
- Shared package hdc_pkg holds FEATURE_COUNT, FEAT_W, CLASS_W, NUM_CLASSES and a loader_state_t enum: IDLE, FILL, RESYNC, LAUNCH, WAIT, FIN_TRAIN, FIN_TEST, DONE.
- One natural sub-module, feature_frame_assembler: word_idx counter, register array and frame/label checks, reporting frame_ok/frame_bad to the sequencing FSM.

Test Plan:
- Reset/idle: nrst=0 for 2 cycles, FEATURE_COUNT=4 -> all outputs 0, s_ready=0, busy=0; start, then stream words 1,2,3,4 with label 7 -> start_mapping pulse one cycle after the 4th beat; input_values={1,2,3,4}; class_select_bits=7.
- Phase sequencing: TRAIN_SAMPLES=2, TEST_SAMPLES=3, sample_done returned 5 cycles after each start_mapping -> exactly 2 start_mapping pulses, then training_dataset_finished; 3 more pulses, then testing_dataset_finished; state DONE, busy=0.
- Backpressure/bubbles: random s_valid gaps, and sample_done delayed 50 cycles -> s_ready=0 throughout WAIT; no words lost; input_values stable until the next FILL write.
- Short/long frames: 3-word frame with s_last on the 3rd -> frame_error=1, no launch. 6-word frame -> RESYNC; the following valid frame launches; sample_cnt unaffected by either bad frame.
- Bad label: label 26 -> label_error=1, sample dropped; the next frame with label 25 launches with class_select_bits=25.
- en and reset mid-run: en=0 in WAIT while sample_done pulses -> ignored and state held. Later nrst=0 during FILL -> IDLE with no finished pulse emitted.
